whack_game_core: RTL and testbench
==================================

Name: whack_game_core

Overview:
Parametrised successor to the single-FSM whack-a-mole controller. It supports N targets, multi-target rounds with per-target hit tracking, lives and a per-round timeout, tick-based timers, and a score-driven difficulty level. It sits between the external RNG (rand_bits) and the display/score drivers; targets drives the lit segments directly.

Parameters:
N_TARGETS, 7, number of targets/buttons
SCORE_W, 8, score width; score saturates at 2^SCORE_W-1
TIMER_W, 16, width of game and round timers
GAME_TICKS, 60000, game length in ticks
ROUND_BASE, 5000, round length at level 0 (ticks)
ROUND_STEP, 1000, round-length reduction per level
ROUND_MIN, 2000, round-length floor
LEVEL_STEP, 5, score points per difficulty level
MAX_LIT, 4, maximum lit targets per round (must be <= N_TARGETS)
LIVES, 3, lives per game; LIVES_W = $clog2(LIVES+1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start/restart request, level-sampled in IDLE or OVER
tick  in  1  timer enable; both timers decrement only when tick=1
btn  in  N_TARGETS  synchronised, active-high buttons
rand_bits  in  N_TARGETS  random word from RNG, sampled in ARM
targets  out  N_TARGETS  currently lit, unhit targets
score  out  SCORE_W  current score
lives  out  LIVES_W  remaining lives
state  out  2  IDLE=0, ARM=1, PLAY=2, OVER=3
hit  out  1  one-cycle pulse when a round is won
miss  out  1  one-cycle pulse on wrong press or round timeout
game_over  out  1  high while in OVER
round_left  out  TIMER_W  round ticks remaining
game_left  out  TIMER_W  game ticks remaining

Behaviour:
- Reset values: state=IDLE, targets=0, score=0, lives=LIVES, hit=0, miss=0, game_over=0, round_left=0, game_left=GAME_TICKS, lockout=0, btn_prev=all-ones. Because btn_prev resets to all-ones, a button held through reset does not produce an edge.
- Edge detection: edge = btn & ~btn_prev & ~lockout. btn_prev updates every cycle in every state.
- Level: level = min(score/LEVEL_STEP, MAX_LIT-1); num_lit = level+1; preset = max(ROUND_BASE - level*ROUND_STEP, ROUND_MIN). All arithmetic saturates, with no wrap.
- Pattern rule:
  - Scan rand_bits from bit 0 upward and take set bits until num_lit are chosen.
  - If fewer than num_lit are set, fill the lowest still-clear bits from bit 0 upward.
  - The result always has exactly num_lit bits set.
- IDLE: start=1 -> ARM next cycle. Also clears score, sets lives=LIVES, game_left=GAME_TICKS.
- ARM (exactly 1 cycle): targets<=pattern, round_left<=preset, lockout<=0 -> PLAY.
- PLAY, evaluated each cycle in priority order:
  1. Game timer: game_left==0 -> OVER; targets<=0.
  2. Round won: (targets & ~edge)==0 -> hit=1, score+1 (saturating) -> ARM.
  3. Partial hit: targets<=targets & ~edge.
  4. Wrong press: any edge bit not in targets -> those bits OR into lockout, miss=1. Lives unchanged; stay in PLAY. Locked bits are ignored until the next ARM.
  5. Timeout: round_left==0 with targets!=0 -> miss=1, lives-1. If lives becomes 0 -> OVER, else -> ARM.
- Timer decrement: when tick=1, game_left and round_left decrement and hold at 0.
- Simultaneous events:
  - Round won beats timeout.
  - Round won suppresses a wrong-press miss in the same cycle.
  - Partial hit and wrong press in the same cycle both apply.
  - Game-timer expiry beats everything.
- OVER: game_over=1, targets=0, score and lives frozen. start=1 -> behaves as IDLE start (-> ARM with score=0, lives=LIVES, game_left=GAME_TICKS).
- Reset mid-game: immediate return to reset values. No partial state survives.

Optional Feature:
COMBO_EN:
- Defined: a streak counter (3 bits, saturating at 7) increments on each round won and clears on any miss pulse or on game start. A round won while streak>=3 (4th consecutive win onward) adds 2 to score instead of 1, still saturating. A combo output port (1 bit, high while streak>=3) is added.
- Undefined: no streak logic and no combo port; every round won adds 1.

Test Plan:
1. Reset, start=1, tick=1, rand_bits=7'b0000100 -> ARM then PLAY with targets=0000100. Rising edge on btn[2] -> next cycle hit=1, score=1, state=ARM.
2. Force score to 5, rand_bits=0 -> targets=7'b0000011, round_left=4000. Press btn[0] -> targets=0000010, no hit. Then press btn[1] -> hit, score=6.
3. No presses, tick=1 -> after 5000 ticks miss=1, lives 3->2. Three timeouts -> lives=0, state=OVER, game_over=1, targets=0.
4. targets=0000100, edge on btn[0] -> miss=1, lives=3, lockout[0]=1. Release and re-press btn[0] -> no miss. btn[2] -> hit, and lockout cleared in ARM.
5. GAME_TICKS=100 override -> OVER after 100 ticks, score frozen. start=1 -> score=0, lives=3, game_left=100.
6. Final target edge in the same cycle round_left reaches 0 -> hit=1, miss=0, lives unchanged. With COMBO_EN, the 4th consecutive hit takes score 3->5.

Source files
------------

// File: rtl/whack_game_core.sv
// Whack-a-mole game core: N targets, multi-target rounds, lives, tick-based timers and a score-driven level.
// Defining COMBO_EN builds the streak/combo scoring and adds the combo output port.
module whack_game_core #(
  parameter int N_TARGETS  = 7,
  parameter int SCORE_W    = 8,
  parameter int TIMER_W    = 16,
  parameter int GAME_TICKS = 60000,
  parameter int ROUND_BASE = 5000,
  parameter int ROUND_STEP = 1000,
  parameter int ROUND_MIN  = 2000,
  parameter int LEVEL_STEP = 5,
  parameter int MAX_LIT    = 4,
  parameter int LIVES      = 3,
  localparam int LIVES_W   = $clog2(LIVES + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 tick,
  input  logic [N_TARGETS-1:0] btn,
  input  logic [N_TARGETS-1:0] rand_bits,
  output logic [N_TARGETS-1:0] targets,
  output logic [SCORE_W-1:0]   score,
  output logic [LIVES_W-1:0]   lives,
  output logic [1:0]           state,
  output logic                 hit,
  output logic                 miss,
  output logic                 game_over,
  output logic [TIMER_W-1:0]   round_left,
  output logic [TIMER_W-1:0]   game_left
`ifdef COMBO_EN
  ,
  output logic                 combo
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_PLAY = 2'd2,
    S_OVER = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [N_TARGETS-1:0] targets_q, targets_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [TIMER_W-1:0]   round_left_q, round_left_d;
  logic [TIMER_W-1:0]   game_left_q, game_left_d;
  logic [N_TARGETS-1:0] lockout_q, lockout_d;
  logic [N_TARGETS-1:0] btn_prev_q, btn_prev_d;
`ifdef COMBO_EN
  logic [2:0]           streak_q, streak_d;
`endif

  logic [N_TARGETS-1:0] btn_edge, remain, wrong, pattern;
  logic [TIMER_W-1:0]   preset;
  logic                 game_done, round_won, round_to, last_life;
  logic [1:0]           gain;
  logic [SCORE_W:0]     score_sum;
  logic [SCORE_W-1:0]   score_inc;

  assign btn_edge  = btn & ~btn_prev_q & ~lockout_q;
  assign remain    = targets_q & ~btn_edge;
  assign wrong     = btn_edge & ~targets_q;
  assign game_done = (game_left_q == '0);
  assign round_won = (remain == '0);
  assign round_to  = (round_left_q == '0);
  assign last_life = (lives_q == LIVES_W'(1));

`ifdef COMBO_EN
  assign gain = (streak_q >= 3'd3) ? 2'd2 : 2'd1;
`else
  assign gain = 2'd1;
`endif
  assign score_sum = {1'b0, score_q} + {{(SCORE_W-1){1'b0}}, gain};
  assign score_inc = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

  // Level, round preset and lit pattern for the next round; all derived from the current score.
  always_comb begin
    int lvl;
    int cnt;
    int preset_i;
    lvl = int'(score_q) / LEVEL_STEP;
    if (lvl > MAX_LIT - 1) lvl = MAX_LIT - 1;
    if (lvl * ROUND_STEP + ROUND_MIN >= ROUND_BASE) preset_i = ROUND_MIN;
    else preset_i = ROUND_BASE - lvl * ROUND_STEP;
    preset  = TIMER_W'(preset_i);
    pattern = '0;
    cnt     = 0;
    for (int i = 0; i < N_TARGETS; i++) begin
      if (rand_bits[i] && cnt < lvl + 1) begin
        pattern[i] = 1'b1;
        cnt = cnt + 1;
      end
    end
    for (int i = 0; i < N_TARGETS; i++) begin
      if (!pattern[i] && cnt < lvl + 1) begin
        pattern[i] = 1'b1;
        cnt = cnt + 1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      targets_q    <= '0;
      score_q      <= '0;
      lives_q      <= LIVES_W'(LIVES);
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
      round_left_q <= '0;
      game_left_q  <= TIMER_W'(GAME_TICKS);
      lockout_q    <= '0;
      btn_prev_q   <= '1;
`ifdef COMBO_EN
      streak_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      targets_q    <= targets_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      round_left_q <= round_left_d;
      game_left_q  <= game_left_d;
      lockout_q    <= lockout_d;
      btn_prev_q   <= btn_prev_d;
`ifdef COMBO_EN
      streak_q     <= streak_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_OVER: if (start) state_d = S_ARM;
      S_ARM:          state_d = S_PLAY;
      S_PLAY: begin
        if (game_done)      state_d = S_OVER;
        else if (round_won) state_d = S_ARM;
        else if (round_to)  state_d = last_life ? S_OVER : S_ARM;
      end
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    targets_d    = targets_q;
    score_d      = score_q;
    lives_d      = lives_q;
    hit_d        = 1'b0;
    miss_d       = 1'b0;
    round_left_d = round_left_q;
    game_left_d  = game_left_q;
    lockout_d    = lockout_q;
    btn_prev_d   = btn;
`ifdef COMBO_EN
    streak_d     = streak_q;
`endif
    // Timers only run while a game is in progress.
    if (tick && (state_q == S_ARM || state_q == S_PLAY)) begin
      if (round_left_q != '0) round_left_d = round_left_q - TIMER_W'(1);
      if (game_left_q != '0)  game_left_d  = game_left_q - TIMER_W'(1);
    end
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          score_d     = '0;
          lives_d     = LIVES_W'(LIVES);
          game_left_d = TIMER_W'(GAME_TICKS);
`ifdef COMBO_EN
          streak_d    = '0;
`endif
        end
      end
      S_ARM: begin
        targets_d    = pattern;
        round_left_d = preset;
        lockout_d    = '0;
      end
      S_PLAY: begin
        if (game_done) begin
          targets_d = '0;
        end else if (round_won) begin
          targets_d = '0;
          hit_d     = 1'b1;
          score_d   = score_inc;
`ifdef COMBO_EN
          if (streak_q != 3'd7) streak_d = streak_q + 3'd1;
`endif
        end else begin
          targets_d = remain;
          if (wrong != '0) begin
            lockout_d = lockout_q | wrong;
            miss_d    = 1'b1;
          end
          if (round_to) begin
            miss_d  = 1'b1;
            lives_d = lives_q - LIVES_W'(1);
            if (last_life) targets_d = '0;
          end
`ifdef COMBO_EN
          if (miss_d) streak_d = '0;
`endif
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    targets    = targets_q;
    score      = score_q;
    lives      = lives_q;
    state      = state_q;
    hit        = hit_q;
    miss       = miss_q;
    game_over  = (state_q == S_OVER);
    round_left = round_left_q;
    game_left  = game_left_q;
`ifdef COMBO_EN
    combo      = (streak_q >= 3'd3);
`endif
  end

endmodule

// File: tb/tb_whack_game_core.sv
// Bench for whack_game_core: directed opening moves, then randomized play checked every cycle against a behavioural model.
module tb_whack_game_core;
  localparam int N  = 7;
  localparam int SW = 4;
  localparam int TW = 16;
  localparam int GT = 300;
  localparam int RB = 40;
  localparam int RS = 10;
  localparam int RM = 15;
  localparam int LS = 2;
  localparam int ML = 4;
  localparam int LV = 3;
  localparam int LW = $clog2(LV + 1);
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n, start, tick;
  logic [N-1:0]  btn, rand_bits, targets;
  logic [SW-1:0] score;
  logic [LW-1:0] lives;
  logic [1:0]    state;
  logic          hit, miss, game_over;
  logic [TW-1:0] round_left, game_left;
`ifdef COMBO_EN
  logic          combo;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Model state
  int           m_state, m_score, m_lives, m_round, m_game, m_streak;
  logic [N-1:0] m_targets, m_lock, m_prev;
  bit           m_hit, m_miss;

  whack_game_core #(
    .N_TARGETS(N), .SCORE_W(SW), .TIMER_W(TW), .GAME_TICKS(GT), .ROUND_BASE(RB),
    .ROUND_STEP(RS), .ROUND_MIN(RM), .LEVEL_STEP(LS), .MAX_LIT(ML), .LIVES(LV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tick(tick), .btn(btn), .rand_bits(rand_bits),
    .targets(targets), .score(score), .lives(lives), .state(state), .hit(hit), .miss(miss),
    .game_over(game_over), .round_left(round_left), .game_left(game_left)
`ifdef COMBO_EN
    , .combo(combo)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Chosen targets: the set bits of r in ascending order, then the clear bits, first k of that list.
  function automatic logic [N-1:0] pick(input logic [N-1:0] r, input int k);
    int q[$];
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < N; i++) if (r[i]) q.push_back(i);
    for (int i = 0; i < N; i++) if (!r[i]) q.push_back(i);
    for (int j = 0; j < k; j++) p[q[j]] = 1'b1;
    return p;
  endfunction

  task automatic m_reset();
    m_state = 0; m_targets = '0; m_score = 0; m_lives = LV; m_hit = 0; m_miss = 0;
    m_round = 0; m_game = GT; m_lock = '0; m_prev = '1; m_streak = 0;
  endtask

  task automatic m_step(input bit s, input bit t, input logic [N-1:0] b, input logic [N-1:0] r);
    logic [N-1:0] e, bad;
    int old_round, old_game, lvl;
    e = b & ~m_prev & ~m_lock;
    m_prev = b;
    m_hit = 0;
    m_miss = 0;
    old_round = m_round;
    old_game = m_game;
    if (t && (m_state == 1 || m_state == 2)) begin
      if (m_round > 0) m_round--;
      if (m_game > 0) m_game--;
    end
    case (m_state)
      0, 3: if (s) begin
        m_score = 0; m_lives = LV; m_game = GT; m_streak = 0; m_state = 1;
      end
      1: begin
        lvl = m_score / LS;
        if (lvl > ML - 1) lvl = ML - 1;
        m_targets = pick(r, lvl + 1);
        m_round = RB - lvl * RS;
        if (m_round < RM) m_round = RM;
        m_lock = '0;
        m_state = 2;
      end
      default: begin
        if (old_game == 0) begin
          m_state = 3; m_targets = '0;
        end else if ((m_targets & ~e) == '0) begin
          m_hit = 1;
`ifdef COMBO_EN
          m_score += (m_streak >= 3) ? 2 : 1;
`else
          m_score += 1;
`endif
          if (m_score > SMAX) m_score = SMAX;
          if (m_streak < 7) m_streak++;
          m_targets = '0;
          m_state = 1;
        end else begin
          bad = e & ~m_targets;
          m_targets = m_targets & ~e;
          if (bad != '0) begin
            m_lock = m_lock | bad; m_miss = 1;
          end
          if (old_round == 0) begin
            m_miss = 1;
            m_lives--;
            if (m_lives == 0) begin
              m_state = 3; m_targets = '0;
            end else m_state = 1;
          end
          if (m_miss) m_streak = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    chk("state", state, m_state);
    chk("targets", targets, m_targets);
    chk("score", score, m_score);
    chk("lives", lives, m_lives);
    chk("hit", hit, m_hit);
    chk("miss", miss, m_miss);
    chk("game_over", game_over, m_state == 3);
    chk("round_left", round_left, m_round);
    chk("game_left", game_left, m_game);
`ifdef COMBO_EN
    chk("combo", combo, m_streak >= 3);
`endif
  endtask

  // Called right after a falling edge: drive inputs, advance the model, then check at the next falling edge.
  task automatic step(input bit s, input bit t, input logic [N-1:0] b, input logic [N-1:0] r, input bit rst);
    start = s; tick = t; btn = b; rand_bits = r; rst_n = !rst;
    if (rst) m_reset();
    else m_step(s, t, b, r);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [N-1:0] b, p2, p0, p5;
    int idx[$];
    bit hands_off;
    p2 = 7'b0000100;
    p0 = 7'b0000001;
    p5 = 7'b0000101;
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; btn = '1; rand_bits = '0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_lives", lives, LV);
    chk("rst_game_left", game_left, GT);
    chk("rst_round_left", round_left, 0);
    chk("rst_targets", targets, 0);
    check_all();

    step(1, 1, '0, p2, 0);
    chk("tp1_arm", state, 1);
    step(0, 1, '0, p2, 0);
    chk("tp1_targets", targets, p2);
    chk("tp1_round_left", round_left, RB);
    step(0, 1, p2, p2, 0);
    chk("tp1_hit", hit, 1);
    chk("tp1_score", score, 1);
    chk("tp1_state", state, 1);
    step(0, 1, '0, p2, 0);
    step(0, 1, p0, p2, 0);
    chk("tp4_miss", miss, 1);
    chk("tp4_lives", lives, LV);
    step(0, 1, '0, p2, 0);
    step(0, 1, p0, p2, 0);
    chk("tp4_locked", miss, 0);
    step(0, 1, p5, p2, 0);
    chk("tp4_hit", hit, 1);
    chk("tp4_score", score, 2);

    hands_off = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc % 700 == 0) hands_off = ($urandom_range(2, 0) == 0);
      b = '0;
      if (!hands_off && !(btn != '0 && $urandom_range(1, 0) == 1)) begin
        idx.delete();
        for (int i = 0; i < N; i++) if (m_targets[i]) idx.push_back(i);
        if (idx.size() > 0 && $urandom_range(9, 0) < 6) b[idx[$urandom_range(idx.size() - 1, 0)]] = 1'b1;
        else if ($urandom_range(9, 0) < 3) b = m_targets;
        else b = N'($urandom);
      end
      step(($urandom_range(3, 0) == 0), ($urandom_range(9, 0) < 8), b, N'($urandom),
           ($urandom_range(799, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
